// File: rtl/key_scan_pkg.sv
// Shared constants for the 4x4 key matrix scanner: FSM encoding, row drive
// patterns and the idle column value.
package key_scan_pkg;

    localparam logic [1:0] StScan     = 2'd0;
    localparam logic [1:0] StDebounce = 2'd1;
    localparam logic [1:0] StHeld     = 2'd2;
    localparam logic [1:0] StRelease  = 2'd3;

    localparam logic [3:0] RowDrive0 = 4'b1110;
    localparam logic [3:0] RowDrive1 = 4'b1101;
    localparam logic [3:0] RowDrive2 = 4'b1011;
    localparam logic [3:0] RowDrive3 = 4'b0111;

    localparam logic [3:0] ColIdle = 4'b1111;

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        logic [3:0] drive;
        unique case (idx)
            2'd0:    drive = RowDrive0;
            2'd1:    drive = RowDrive1;
            2'd2:    drive = RowDrive2;
            default: drive = RowDrive3;
        endcase
        return drive;
    endfunction

    // Index of the lowest active-low column; only meaningful when cols != ColIdle.
    function automatic logic [1:0] low_col(input logic [3:0] cols);
        logic [1:0] idx;
        if (!cols[0]) begin
            idx = 2'd0;
        end else if (!cols[1]) begin
            idx = 2'd1;
        end else if (!cols[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer for the asynchronous, active-low column sense lines.
module col_sync
    import key_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] col_s
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= ColIdle;
            sync_q <= ColIdle;
        end else begin
            meta_q <= col;
            sync_q <= meta_q;
        end
    end

    assign col_s = sync_q;

endmodule

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, debounces the
// first key found for press and release, and reports it as row*4 + col.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned DivW   = $clog2(SCAN_DIV);
    localparam int unsigned MatchW = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DivW-1:0]   DivLast   = DivW'(SCAN_DIV - 1);
    localparam logic [MatchW-1:0] MatchDone = MatchW'(DEBOUNCE_CNT);
    localparam logic [MatchW-1:0] MatchOne  = MatchW'(1);

    logic [3:0] col_s;

    logic [DivW-1:0]   div_q, div_d;
    logic [1:0]        state_q, state_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [MatchW-1:0] match_q, match_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_down_q, key_down_d;
    logic [3:0]        row_q;

    logic              tick;
    logic              latched_low;
    logic [MatchW-1:0] match_inc;

    col_sync u_col_sync (
        .clk   (clk),
        .rst   (rst),
        .col   (col),
        .col_s (col_s)
    );

    always_comb begin
        tick        = (div_q == DivLast);
        div_d       = tick ? '0 : div_q + 1'b1;
        latched_low = ~col_s[col_idx_q];
        match_inc   = match_q + 1'b1;

        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        match_d     = match_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;

        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (col_s == ColIdle) begin
                        row_idx_d = row_idx_q + 2'd1;
                    end else begin
                        col_idx_d = low_col(col_s);
                        match_d   = '0;
                        state_d   = StDebounce;
                    end
                end
                StDebounce: begin
                    if (latched_low) begin
                        match_d = match_inc;
                        if (match_inc == MatchDone) begin
                            key_code_d  = {row_idx_q, col_idx_q};
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            state_d     = StHeld;
                        end
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                        state_d   = StScan;
                    end
                end
                StHeld: begin
                    if (!latched_low) begin
                        // The first high sample already counts toward release.
                        if (MatchOne == MatchDone) begin
                            key_down_d = 1'b0;
                            row_idx_d  = row_idx_q + 2'd1;
                            match_d    = '0;
                            state_d    = StScan;
                        end else begin
                            match_d = MatchOne;
                            state_d = StRelease;
                        end
                    end
                end
                StRelease: begin
                    if (!latched_low) begin
                        match_d = match_inc;
                        if (match_inc == MatchDone) begin
                            key_down_d = 1'b0;
                            row_idx_d  = row_idx_q + 2'd1;
                            state_d    = StScan;
                        end
                    end else begin
                        state_d = StHeld;
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            state_q     <= StScan;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            match_q     <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            row_q       <= RowDrive0;
        end else begin
            div_q       <= div_d;
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            match_q     <= match_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            row_q       <= row_drive(row_idx_d);
        end
    end

    assign row       = row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clock cycles per row dwell and per debounce sample (1 ms at 100 MHz); legal range >= 4.
REQ-002 Parameter DEBOUNCE_CNT, default 20: consecutive matching samples required to accept a press or release; legal range >= 1.
REQ-003 Port clk, input, 1: single 100 MHz clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port row, output, 4: matrix row drive, active-low, exactly one bit low at all times.
REQ-006 Port col, input, 4: matrix column sense, active-low (pulled up externally), asynchronous to clk.
REQ-007 Port key_code, output, 4: code of the last accepted key, row_idx*4 + col_idx.
REQ-008 Port key_valid, output, 1: one-cycle pulse when a press is accepted.
REQ-009 Port key_down, output, 1: high from press acceptance until release acceptance.

Function
REQ-010 col SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (col_s).
REQ-011 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; a "sample tick" is the cycle the counter equals SCAN_DIV-1.
REQ-012 The FSM SHALL have states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-013 In SCAN, at each sample tick with col_s == 4'b1111, row SHALL rotate to the next row (1110->1101->1011->0111->1110).
REQ-014 In SCAN, at a sample tick with any col_s bit low, the FSM SHALL latch row_idx and col_idx, freeze row, clear the match counter, and enter DEBOUNCE.
REQ-015 If more than one col_s bit is low, the lowest-index low bit SHALL win.
REQ-016 In DEBOUNCE, at each sample tick, a latched column bit that is still low SHALL increment the match counter; otherwise the FSM SHALL return to SCAN and advance row.
REQ-017 When the match counter reaches DEBOUNCE_CNT, the block SHALL drive key_code = row_idx*4 + col_idx, pulse key_valid for exactly one cycle, set key_down, and enter HELD.
REQ-018 In HELD, row SHALL stay frozen; a sample tick with the latched column bit high SHALL enter RELEASE with the match counter set to 1.
REQ-019 In RELEASE, each sample tick with the latched bit high SHALL increment the counter, and a low bit SHALL return the FSM to HELD.
REQ-020 When the RELEASE counter reaches DEBOUNCE_CNT, key_down SHALL clear, row SHALL advance, and the FSM SHALL enter SCAN.
REQ-021 key_code SHALL hold its value until the next accepted press.
REQ-022 Press latency SHALL be DEBOUNCE_CNT sample ticks after the detecting tick, plus 2 sync cycles.
REQ-023 Keys in other rows SHALL be ignored while in DEBOUNCE, HELD or RELEASE.
REQ-024 key_valid SHALL never assert twice for one uninterrupted hold.

Reset
REQ-025 With rst high at a clock edge, the block SHALL set: row = 4'b1110, key_code = 0, key_valid = 0, key_down = 0, state SCAN, all counters 0, synchronizer flops 4'b1111.
REQ-026 Reset mid-press SHALL abort without a key_valid pulse; a key still held after reset is re-detected and debounced from zero.

Structure
REQ-027 Shared package key_scan_pkg SHALL hold the FSM state encoding, the row rotation constants and the idle column value 4'b1111.
REQ-028 The column synchronizer SHALL be sub-module col_sync (4-bit, 2-flop, reset to all ones); everything else stays in key_scan.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, clock period 10 ns, rst high for the first 3 cycles)
REQ-029 Idle, col=1111 -> row cycles 1110,1101,1011,0111 every 4 clocks; key_valid and key_down stay 0.
REQ-030 Hold col[2] low while row=1011 (row 2) -> after 3 ticks, exactly one key_valid pulse with key_code=10, key_down=1, and row frozen at 1011.
REQ-031 Press lasting 1 tick, then released -> no key_valid; scanning resumes at row 0111.
REQ-032 Release after acceptance with a 1-tick bounce low -> key_down stays 1; key_down clears only after 3 consecutive high ticks, then row=0111.
REQ-033 col=1001 on row 0 -> key_code=1 (lowest index wins).
REQ-034 Assert rst during DEBOUNCE -> no key_valid, row=1110, and all outputs at reset values on the next cycle.
